// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding,
// length-header size and default parameter values.
package loader_pkg;

  localparam int unsigned DEF_ADDR_W    = 14;
  localparam int unsigned DEF_MAX_WORDS = 16384;
  localparam int unsigned DEF_TIMEOUT   = 1000000;

  // Bytes per 32-bit word; also the size of the length header.
  localparam int unsigned LEN_BYTES = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } state_t;

endpackage

// File: rtl/byte_assembler.sv
// Shifts accepted bytes into a little-endian 32-bit word.
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   clear         restart byte index at byte 0
//   accept        a byte is taken this cycle
//   data          byte value
//   word_c        word including the current byte (valid with last_c)
//   last_c        current accepted byte completes a word
module byte_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  data,
  output logic [31:0] word_c,
  output logic        last_c
);

  localparam int unsigned IDX_W = $clog2(LEN_BYTES);
  localparam int unsigned SH_W  = 8 * (LEN_BYTES - 1);

  logic [IDX_W-1:0] idx;
  logic [SH_W-1:0]  shreg;

  // Newest byte lands in the top lane; earlier bytes drift down to bit 0.
  assign word_c = {data, shreg};
  assign last_c = accept && (idx == IDX_W'(LEN_BYTES - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      idx   <= '0;
      shreg <= '0;
    end else if (clear) begin
      idx   <= '0;
    end else if (accept) begin
      idx   <= idx + IDX_W'(1);
      shreg <= word_c[31:8];
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed little-endian program image from a byte stream
// into instruction memory while holding the core in reset.
// Ports:
//   clk, rst              clock, synchronous active-low reset
//   start                 begin a load (honoured in IDLE/DONE/ERR only)
//   rx_valid, rx_data     byte source
//   rx_ready              loader accepts a byte this cycle
//   mem_we/addr/wdata     instruction-memory write port
//   busy, done, err       load status
//   cpu_hold              keeps the fetch unit in reset
//   word_count            words written in the current load
module imem_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned MAX_WORDS = DEF_MAX_WORDS,
  parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_hold,
  output logic [ADDR_W:0]   word_count
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

  state_t            state, state_d;
  logic [CNT_W-1:0]  len_q, len_d, word_count_d;
  logic [TO_W-1:0]   tout_q, tout_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [31:0]       mem_wdata_d;
  logic              rx_ready_d, mem_we_d, busy_d, done_d, err_d, cpu_hold_d;

  logic              accept_c, restart_c, last_c;
  logic [31:0]       word_c;

  assign accept_c  = rx_valid && rx_ready;
  assign restart_c = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);

  byte_assembler u_asm (
    .clk    (clk),
    .rst    (rst),
    .clear  (restart_c),
    .accept (accept_c),
    .data   (rx_data),
    .word_c (word_c),
    .last_c (last_c)
  );

  // Next state and next values of all registered outputs.
  always_comb begin
    state_d      = state;
    len_d        = len_q;
    word_count_d = word_count;
    tout_d       = tout_q;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;

    case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d      = ST_LEN;
          word_count_d = '0;
          tout_d       = '0;
        end
      end
      ST_LEN, ST_DATA: begin
        tout_d = accept_c ? '0 : tout_q + TO_W'(1);
        if (!accept_c && tout_q == TO_W'(TIMEOUT - 1)) begin
          state_d = ST_ERR;
        end else if (last_c) begin
          if (state == ST_LEN) begin
            if (word_c == 32'd0)                 state_d = ST_DONE;
            else if (word_c > 32'(MAX_WORDS))    state_d = ST_ERR;
            else begin
              state_d = ST_DATA;
              len_d   = CNT_W'(word_c);
            end
          end else begin
            state_d     = ST_WRITE;
            mem_addr_d  = word_count[ADDR_W-1:0];
            mem_wdata_d = word_c;
          end
        end
      end
      ST_WRITE: begin
        word_count_d = word_count + CNT_W'(1);
        state_d      = (word_count_d == len_q) ? ST_DONE : ST_DATA;
      end
      default: state_d = ST_IDLE;
    endcase

    rx_ready_d = (state_d == ST_LEN) || (state_d == ST_DATA);
    mem_we_d   = (state_d == ST_WRITE);
    busy_d     = rx_ready_d || mem_we_d;
    done_d     = (state_d == ST_DONE);
    err_d      = (state_d == ST_ERR);
    cpu_hold_d = busy_d || err_d;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      len_q      <= '0;
      tout_q     <= '0;
      word_count <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rx_ready   <= 1'b0;
      mem_we     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      cpu_hold   <= 1'b0;
    end else begin
      state      <= state_d;
      len_q      <= len_d;
      tout_q     <= tout_d;
      word_count <= word_count_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      rx_ready   <= rx_ready_d;
      mem_we     <= mem_we_d;
      busy       <= busy_d;
      done       <= done_d;
      err        <= err_d;
      cpu_hold   <= cpu_hold_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as bytes
// are driven and popped when mem_we is observed.
module tb_imem_loader;

  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned MAX_WORDS = 16;
  localparam int unsigned TIMEOUT   = 40;

  logic              clk = 1'b0;
  logic              rst, start, rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready, mem_we, busy, done, err, cpu_hold;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W:0]   word_count;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   wr_cyc[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_wr    = 0;
  int   cyc     = 0;
  logic [31:0] last_addr = '0;

  imem_loader #(
    .ADDR_W    (ADDR_W),
    .MAX_WORDS (MAX_WORDS),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .cpu_hold   (cpu_hold),
    .word_count (word_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write monitor / scoreboard pop.
  always @(negedge clk) begin
    if (mem_we) begin
      n_wr++;
      wr_cyc.push_back(cyc);
      last_addr = 32'(mem_addr);
      if (sb.size() == 0) begin
        check("unexpected_we", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wr_addr", 64'(mem_addr), 64'(e.addr));
        check("wr_data", 64'(mem_wdata), 64'(e.data));
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) check("rx_ready_wait", 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic wait_end();
    int guard = 0;
    rx_valid = 1'b0;
    while (!(done || err) && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) check("end_wait", 64'd0, 64'd1);
  endtask

  task automatic push_exp(input int a, input logic [31:0] d);
    exp_t e;
    e.addr = 32'(a);
    e.data = d;
    sb.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no_finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [31:0] w;
    rst = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_ready", 64'(rx_ready), 0);
    check("rst_mem_we",   64'(mem_we), 0);
    check("rst_busy",     64'(busy), 0);
    check("rst_done",     64'(done), 0);
    check("rst_err",      64'(err), 0);
    check("rst_cpu_hold", 64'(cpu_hold), 0);
    check("rst_wcount",   64'(word_count), 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Single word load.
    pulse_start();
    check("t1_rx_ready", 64'(rx_ready), 1);
    check("t1_busy",     64'(busy), 1);
    check("t1_hold",     64'(cpu_hold), 1);
    push_exp(0, 32'h0000_0013);
    send_word(32'd1);
    send_word(32'h0000_0013);
    wait_end();
    check("t1_done",   64'(done), 1);
    check("t1_hold_0", 64'(cpu_hold), 0);
    check("t1_busy_0", 64'(busy), 0);
    check("t1_wcount", 64'(word_count), 1);
    check("t1_writes", 64'(n_wr), 1);

    // Two words back to back: 5-cycle spacing.
    pulse_start();
    check("t2_done_clr", 64'(done), 0);
    base = n_wr;
    send_word(32'd2);
    push_exp(0, 32'h0050_0093); send_word(32'h0050_0093);
    push_exp(1, 32'h0010_0113); send_word(32'h0010_0113);
    wait_end();
    check("t2_wcount", 64'(word_count), 2);
    check("t2_writes", 64'(n_wr - base), 2);
    if (wr_cyc.size() >= 2)
      check("t2_spacing", 64'(wr_cyc[wr_cyc.size()-1] - wr_cyc[wr_cyc.size()-2]), 5);
    else
      check("t2_spacing", 64'(wr_cyc.size()), 2);

    // Zero length: DONE right after the header.
    pulse_start();
    base = n_wr;
    send_word(32'd0);
    rx_valid = 1'b0;
    check("t3_done",   64'(done), 1);
    check("t3_busy",   64'(busy), 0);
    check("t3_wcount", 64'(word_count), 0);
    @(posedge clk); #1;
    check("t3_writes", 64'(n_wr - base), 0);

    // Oversize length aborts; restart then full-size load with start noise.
    pulse_start();
    send_word(32'(MAX_WORDS + 1));
    rx_valid = 1'b0;
    check("t4_err",      64'(err), 1);
    check("t4_hold",     64'(cpu_hold), 1);
    check("t4_rx_ready", 64'(rx_ready), 0);
    check("t4_busy",     64'(busy), 0);
    pulse_start();
    check("t4_restart_ready", 64'(rx_ready), 1);
    check("t4_restart_err",   64'(err), 0);
    send_word(32'(MAX_WORDS));
    for (int i = 0; i < int'(MAX_WORDS); i++) begin
      w = $urandom;
      push_exp(i, w);
      start = (i == 3);
      send_word(w);
    end
    start = 1'b0;
    wait_end();
    check("t4_done",      64'(done), 1);
    check("t4_wcount",    64'(word_count), 64'(MAX_WORDS));
    check("t4_last_addr", 64'(last_addr), 64'(MAX_WORDS - 1));
    check("t4_sb_empty",  64'(sb.size()), 0);

    // Stall mid-word until timeout.
    pulse_start();
    base = n_wr;
    send_word(32'd3);
    push_exp(0, 32'hCAFE_F00D);
    send_word(32'hCAFE_F00D);
    send_byte(8'hAA);
    rx_valid = 1'b0;
    repeat (TIMEOUT - 1) @(posedge clk);
    #1;
    check("t5_err_early", 64'(err), 0);
    @(posedge clk); #1;
    check("t5_err",    64'(err), 1);
    check("t5_hold",   64'(cpu_hold), 1);
    check("t5_busy",   64'(busy), 0);
    check("t5_writes", 64'(n_wr - base), 1);
    check("t5_wcount", 64'(word_count), 1);

    // Reset mid-DATA, then a fresh load from address 0.
    pulse_start();
    send_word(32'd3);
    send_byte(8'h11);
    send_byte(8'h22);
    rx_valid = 1'b0;
    rst = 1'b0;
    base = n_wr;
    @(posedge clk); #1;
    check("t6_rx_ready", 64'(rx_ready), 0);
    check("t6_mem_we",   64'(mem_we), 0);
    check("t6_addr",     64'(mem_addr), 0);
    check("t6_wdata",    64'(mem_wdata), 0);
    check("t6_busy",     64'(busy), 0);
    check("t6_done",     64'(done), 0);
    check("t6_err",      64'(err), 0);
    check("t6_hold",     64'(cpu_hold), 0);
    check("t6_wcount",   64'(word_count), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t6_writes",   64'(n_wr - base), 0);
    pulse_start();
    push_exp(0, 32'h1234_5678);
    send_word(32'd1);
    send_word(32'h1234_5678);
    wait_end();
    check("t6_done2",    64'(done), 1);
    check("t6_wcount2",  64'(word_count), 1);
    check("t6_sb_empty", 64'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 14, word-address width of instruction memory write port.
REQ-002 Parameter MAX_WORDS, default 16384, largest accepted program length in words.
REQ-003 Parameter TIMEOUT, default 1000000, idle cycles between accepted bytes before abort.
REQ-004 clk  input  1  system clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  one-cycle pulse; begins a load from IDLE, DONE or ERR.
REQ-007 rx_valid  input  1  byte-source data valid.
REQ-008 rx_data  input  8  byte from source.
REQ-009 rx_ready  output  1  loader can accept a byte.
REQ-010 mem_we  output  1  one-cycle instruction-memory write strobe.
REQ-011 mem_addr  output  ADDR_W  word address of write.
REQ-012 mem_wdata  output  32  word written.
REQ-013 busy  output  1  load in progress.
REQ-014 done  output  1  load completed; level.
REQ-015 err  output  1  load aborted; level, sticky.
REQ-016 cpu_hold  output  1  holds the core's fetch unit in reset while high.
REQ-017 word_count  output  ADDR_W+1  words written in current load.

Function
REQ-018 States: IDLE, LEN, DATA, WRITE, DONE, ERR.
REQ-019 Byte accepted on a cycle with rx_valid and rx_ready both high; rx_ready high only in LEN and DATA.
REQ-020 Stream format: 4-byte little-endian length L (words), then 4*L payload bytes, each word little-endian.
REQ-021 IDLE/DONE/ERR + start -> LEN; clears word_count, byte index, timeout counter, done, err; sets busy, cpu_hold.
REQ-022 start while in LEN, DATA or WRITE is ignored.
REQ-023 LEN: after 4th byte, L==0 -> DONE; L>MAX_WORDS -> ERR; else -> DATA; transition on the cycle after the 4th acceptance.
REQ-024 DATA: after 4th byte of a word -> WRITE.
REQ-025 WRITE: exactly one cycle; mem_we=1, mem_addr=word_count[ADDR_W-1:0], mem_wdata=assembled word; word_count increments at end of cycle.
REQ-026 WRITE exit: incremented word_count==L -> DONE, else -> DATA.
REQ-027 Maximum rate: one word per 5 cycles with rx_valid held high.
REQ-028 mem_we never high outside WRITE; mem_addr and mem_wdata hold last values otherwise.
REQ-029 Timeout counter increments each cycle in LEN/DATA without acceptance, clears on acceptance; reaching TIMEOUT -> ERR.
REQ-030 DONE: done=1, busy=0, cpu_hold=0.
REQ-031 ERR: err=1, busy=0, cpu_hold=1 (core stays held on a bad image).
REQ-032 L==MAX_WORDS accepted; final write address MAX_WORDS-1.

Reset
REQ-033 rst low at any clock edge -> IDLE, mid-load included; no write in that cycle.
REQ-034 Reset values: rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, cpu_hold=0, word_count=0, internal counters 0.

Structure
REQ-035 State encoding, length-header byte count (4) and default parameter values in shared package loader_pkg.
REQ-036 One sub-module, byte_assembler: shifts 4 bytes into a little-endian word, flags 4th byte.

Verification
REQ-037 start, bytes 01 00 00 00, 13 00 00 00 -> one mem_we, addr 0, data 0x00000013; done=1, cpu_hold=0.
REQ-038 L=2, words 0x00500093, 0x00100113, rx_valid held -> writes addr 0 and 1, 5 cycles apart; word_count=2.
REQ-039 L=0 -> no mem_we; DONE the cycle after 4th length byte.
REQ-040 L=MAX_WORDS+1 -> ERR, err=1, cpu_hold=1, rx_ready=0; subsequent start returns to LEN.
REQ-041 L=3, stall after 5 payload bytes for TIMEOUT cycles -> ERR, exactly one write performed.
REQ-042 rst low mid-DATA -> next cycle all outputs at reset values; start plus fresh stream loads from addr 0.
